// File: rtl/key_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module      : key_bcd_counter
// Description : Debounced push-key BCD counter. Each key adds or subtracts a
//               power of ten to a packed multi-digit BCD value, with optional
//               auto-repeat while a key is held.
// Revision    : 1.0 - initial release
// ============================================================================
module key_bcd_counter #(
    parameter int DIGITS       = 6,
    parameter int KEYS         = 4,
    parameter int SAMPLE_DIV   = 2500000,
    parameter int REPEAT_TICKS = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [KEYS-1:0]       key,
    input  logic                  dir,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   num,
    output logic                  en,
    output logic                  upd,
    output logic                  ovf
);

    localparam int               DIV_W      = 24;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SAMPLE_DIV - 1);

    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [KEYS-1:0]     key_meta;
    logic [KEYS-1:0]     key_sync;
    logic [KEYS-1:0]     key_samp;
    logic [KEYS-1:0]     key_deb;
    logic [KEYS-1:0]     deb_nx;
    logic [KEYS-1:0]     press_ev;
    logic [KEYS-1:0]     rpt_ev;
    logic [KEYS-1:0]     key_ev;
    logic                any_ev;
    logic [3:0]          sel_digit;
    logic [4*DIGITS-1:0] num_nx;
    logic                wrap;
    logic                carry;
    logic                cin;
    logic [3:0]          dig;
    logic [3:0]          dig_nx;

    // Sample-tick divider: counts down and reloads, tick is the zero cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= DIV_RELOAD;
        end else if (div_cnt == '0) begin
            div_cnt <= DIV_RELOAD;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    assign tick = (div_cnt == '0);

    // Two-flop synchroniser; resets to the released (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= '1;
            key_sync <= '1;
        end else begin
            key_meta <= key;
            key_sync <= key_meta;
        end
    end

    // Debounce decision: two equal consecutive tick samples flip the state.
    always_comb begin
        deb_nx = key_deb;
        for (int k = 0; k < KEYS; k++) begin
            if (!key_sync[k] && !key_samp[k]) begin
                deb_nx[k] = 1'b1;
            end else if (key_sync[k] && key_samp[k]) begin
                deb_nx[k] = 1'b0;
            end
        end
    end

    // Debounce state and previous-tick sample, advanced only on ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_samp <= '1;
            key_deb  <= '0;
        end else if (tick) begin
            key_samp <= key_sync;
            key_deb  <= deb_nx;
        end
    end

    assign press_ev = {KEYS{tick}} & ~key_deb & deb_nx;

    if (REPEAT_TICKS > 0) begin : g_repeat
        localparam int            RW       = $clog2(REPEAT_TICKS + 1);
        localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_TICKS - 1);

        for (genvar k = 0; k < KEYS; k++) begin : g_key
            logic [RW-1:0] rpt_cnt;
            logic          held;

            // A key counts as held only if it stays pressed through this tick.
            assign held = key_deb[k] & deb_nx[k];

            // Ticks since the last press or repeat event of this key.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rpt_cnt <= '0;
                end else if (tick) begin
                    if (!held || (rpt_cnt == RPT_LAST)) begin
                        rpt_cnt <= '0;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end
            end

            assign rpt_ev[k] = tick & held & (rpt_cnt == RPT_LAST);
        end
    end else begin : g_no_repeat
        assign rpt_ev = '0;
    end

    assign key_ev = press_ev | rpt_ev;

    // Lowest-index key wins when several fire on the same tick.
    always_comb begin
        any_ev    = 1'b0;
        sel_digit = '0;
        for (int k = KEYS - 1; k >= 0; k--) begin
            if (key_ev[k]) begin
                any_ev    = 1'b1;
                sel_digit = 4'(k);
            end
        end
    end

    // BCD add/subtract of 10^sel_digit with ripple carry/borrow over all digits.
    always_comb begin
        num_nx = num;
        carry  = 1'b0;
        cin    = 1'b0;
        dig    = '0;
        dig_nx = '0;
        for (int d = 0; d < DIGITS; d++) begin
            dig    = num[4*d +: 4];
            cin    = carry | (4'(d) == sel_digit);
            dig_nx = dig;
            carry  = 1'b0;
            if (cin) begin
                if (!dir) begin
                    if (dig >= 4'd9) begin
                        dig_nx = 4'd0;
                        carry  = 1'b1;
                    end else begin
                        dig_nx = dig + 4'd1;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        dig_nx = 4'd9;
                        carry  = 1'b1;
                    end else begin
                        dig_nx = dig - 4'd1;
                    end
                end
            end
            num_nx[4*d +: 4] = dig_nx;
        end
        wrap = carry;
    end

    // Counter value and status pulses; clear overrides any same-cycle event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num <= '0;
            upd <= 1'b0;
            ovf <= 1'b0;
        end else begin
            upd <= 1'b0;
            ovf <= 1'b0;
            if (clr) begin
                num <= '0;
                upd <= 1'b1;
            end else if (any_ev) begin
                num <= num_nx;
                upd <= 1'b1;
                ovf <= wrap;
            end
        end
    end

    // Display enable latches on the first sample tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en <= 1'b0;
        end else if (tick) begin
            en <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_bcd_counter
// Description : Directed self-checking bench for key_bcd_counter, one
//               instance without auto-repeat and one with REPEAT_TICKS=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_bcd_counter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  key_a;
    logic        dir_a;
    logic        clr_a;
    logic [23:0] num_a;
    logic        en_a;
    logic        upd_a;
    logic        ovf_a;
    logic [3:0]  key_r;
    logic        dir_r;
    logic        clr_r;
    logic [23:0] num_r;
    logic        en_r;
    logic        upd_r;
    logic        ovf_r;

    int errors;
    int checks;
    int upd_cnt_a;
    int ovf_cnt_a;
    int upd_cnt_r;
    int base_upd;
    int base_ovf;
    bit seen;

    key_bcd_counter #(.DIGITS(6), .KEYS(4), .SAMPLE_DIV(4), .REPEAT_TICKS(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .key(key_a), .dir(dir_a), .clr(clr_a),
        .num(num_a), .en(en_a), .upd(upd_a), .ovf(ovf_a)
    );

    key_bcd_counter #(.DIGITS(6), .KEYS(4), .SAMPLE_DIV(4), .REPEAT_TICKS(3)) dut_r (
        .clk(clk), .rst_n(rst_n), .key(key_r), .dir(dir_r), .clr(clr_r),
        .num(num_r), .en(en_r), .upd(upd_r), .ovf(ovf_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles in which each pulse output is high.
    always @(posedge clk) begin
        if (upd_a) upd_cnt_a <= upd_cnt_a + 1;
        if (ovf_a) ovf_cnt_a <= ovf_cnt_a + 1;
        if (upd_r) upd_cnt_r <= upd_cnt_r + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Press the keys selected by mask on the non-repeating instance.
    task automatic press_a(input logic [3:0] mask);
        key_a = ~mask;
        cyc(16);
        key_a = 4'hF;
        cyc(16);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        upd_cnt_a = 0;
        ovf_cnt_a = 0;
        upd_cnt_r = 0;
        key_a = 4'hF; dir_a = 1'b0; clr_a = 1'b0;
        key_r = 4'hF; dir_r = 1'b0; clr_r = 1'b0;
        rst_n = 1'b0;
        cyc(3);

        check("reset_num", 32'(num_a), 32'h0);
        check("reset_en",  32'(en_a),  32'h0);
        check("reset_upd", 32'(upd_a), 32'h0);
        check("reset_ovf", 32'(ovf_a), 32'h0);
        check("reset_num_r", 32'(num_r), 32'h0);

        rst_n = 1'b1;
        cyc(2);
        check("en_before_tick", 32'(en_a), 32'h0);

        // Key 0 held for three ticks: a single increment.
        key_a = 4'hE;
        cyc(12);
        key_a = 4'hF;
        cyc(16);
        check("single_press_num", 32'(num_a), 32'h000001);
        check("single_press_upd", 32'(upd_cnt_a), 32'd1);
        check("en_after_tick", 32'(en_a), 32'h1);

        // Long hold without auto-repeat still gives one event.
        key_a = 4'hE;
        cyc(60);
        key_a = 4'hF;
        cyc(16);
        check("long_hold_num", 32'(num_a), 32'h000002);
        check("long_hold_upd", 32'(upd_cnt_a), 32'd2);

        // Preload 0x99 then carry into the hundreds.
        for (int i = 0; i < 9; i++) press_a(4'b0010);
        for (int i = 0; i < 7; i++) press_a(4'b0001);
        check("preload_99", 32'(num_a), 32'h000099);
        press_a(4'b0001);
        check("carry_100", 32'(num_a), 32'h000100);
        check("carry_no_ovf", 32'(ovf_cnt_a), 32'd0);
        check("carry_upd_total", 32'(upd_cnt_a), 32'd19);

        // Clear held across a key event: value zero, event dropped, no ovf.
        base_upd = upd_cnt_a;
        clr_a = 1'b1;
        key_a = 4'hE;
        cyc(16);
        clr_a = 1'b0;
        cyc(4);
        key_a = 4'hF;
        cyc(16);
        check("clr_num", 32'(num_a), 32'h0);
        check("clr_upd_cycles", 32'(upd_cnt_a - base_upd), 32'd16);
        check("clr_no_ovf", 32'(ovf_cnt_a), 32'd0);

        // Wrap below zero and above all nines.
        dir_a = 1'b1;
        press_a(4'b0001);
        check("down_wrap_num", 32'(num_a), 32'h999999);
        check("down_wrap_ovf", 32'(ovf_cnt_a), 32'd1);
        dir_a = 1'b0;
        press_a(4'b0001);
        check("up_wrap_num", 32'(num_a), 32'h000000);
        check("up_wrap_ovf", 32'(ovf_cnt_a), 32'd2);
        dir_a = 1'b1;
        press_a(4'b0001);
        check("down_wrap2_num", 32'(num_a), 32'h999999);
        check("down_wrap2_ovf", 32'(ovf_cnt_a), 32'd3);

        // Single-cycle clear, then wraps on the higher digits.
        clr_a = 1'b1;
        cyc(1);
        clr_a = 1'b0;
        cyc(2);
        check("clr_pulse_num", 32'(num_a), 32'h0);
        press_a(4'b1000);
        check("k3_down_num", 32'(num_a), 32'h999000);
        check("k3_down_ovf", 32'(ovf_cnt_a), 32'd4);
        dir_a = 1'b0;
        press_a(4'b0100);
        check("k2_up_num", 32'(num_a), 32'h999100);
        check("k2_up_ovf", 32'(ovf_cnt_a), 32'd4);
        press_a(4'b1000);
        check("k3_up_wrap_num", 32'(num_a), 32'h000100);
        check("k3_up_wrap_ovf", 32'(ovf_cnt_a), 32'd5);

        // Simultaneous keys 1 and 3: only key 1 applies.
        clr_a = 1'b1;
        cyc(1);
        clr_a = 1'b0;
        cyc(2);
        base_upd = upd_cnt_a;
        press_a(4'b1010);
        check("simul_num", 32'(num_a), 32'h000010);
        check("simul_upd", 32'(upd_cnt_a - base_upd), 32'd1);

        // Reset in the middle of debouncing a held key.
        key_a = 4'hE;
        cyc(6);
        rst_n = 1'b0;
        #1;
        check("async_rst_num", 32'(num_a), 32'h0);
        check("async_rst_en", 32'(en_a), 32'h0);
        cyc(1);
        rst_n = 1'b1;
        base_upd = upd_cnt_a;
        base_ovf = ovf_cnt_a;
        cyc(6);
        check("post_rst_no_event", 32'(num_a), 32'h0);
        check("post_rst_no_upd", 32'(upd_cnt_a - base_upd), 32'd0);
        cyc(12);
        check("post_rst_fresh_event", 32'(num_a), 32'h000001);
        check("post_rst_no_ovf", 32'(ovf_cnt_a - base_ovf), 32'd0);
        key_a = 4'hF;
        cyc(16);

        // Auto-repeat instance: key 2 held, initial event plus three repeats.
        base_upd = upd_cnt_r;
        key_r = 4'hB;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (upd_r) seen = 1'b1;
        end
        check("rpt_press_seen", 32'(seen), 32'h1);
        cyc(35);
        key_r = 4'hF;
        cyc(40);
        check("rpt_num", 32'(num_r), 32'h000400);
        check("rpt_upd", 32'(upd_cnt_r - base_upd), 32'd4);
        cyc(40);
        check("rpt_release_hold", 32'(num_r), 32'h000400);
        check("rpt_ovf", 32'(ovf_r), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_bcd_counter.md
KEY_BCD_COUNTER -- requirements
Module: key_bcd_counter

Interface
- REQ-001: Parameter DIGITS, default 6, number of BCD digits in num (legal 1..8).
- REQ-002: Parameter KEYS, default 4, number of keys (legal 1..DIGITS); key[i] adds 10^i.
- REQ-003: Parameter SAMPLE_DIV, default 2500000, clock cycles per key sample tick (legal 2..2^24-1).
- REQ-004: Parameter REPEAT_TICKS, default 0, sample ticks per auto-repeat while a key is held; 0 disables auto-repeat.
- REQ-005: clk  input  1  sole clock, all state on rising edge.
- REQ-006: rst_n  input  1  asynchronous active-low reset.
- REQ-007: key  input  KEYS  raw key levels, active-low (0 = pressed), asynchronous to clk.
- REQ-008: dir  input  1  0 = count up, 1 = count down; sampled in the cycle the event is applied.
- REQ-009: clr  input  1  synchronous active-high clear of num.
- REQ-010: num  output  4*DIGITS  packed BCD value; digit k in num[4k+3:4k].
- REQ-011: en  output  1  display enable; high from the first sample tick onward.
- REQ-012: upd  output  1  one-cycle pulse on each cycle num is written.
- REQ-013: ovf  output  1  one-cycle pulse when an event wraps past all-9s (up) or below zero (down).

Function
- REQ-014: Key inputs SHALL pass a 2-flop synchroniser before any use.
- REQ-015: The tick divider SHALL count SAMPLE_DIV-1 down to 0 and assert an internal tick for one cycle at 0, then reload; first tick SAMPLE_DIV cycles after reset release.
- REQ-016: Per key, debounced state SHALL become pressed when sampled low on 2 consecutive ticks and released when sampled high on 2 consecutive ticks; otherwise hold.
- REQ-017: A press event SHALL be generated on the tick where debounced state goes released->pressed; holding a key SHALL NOT generate further events unless auto-repeat is enabled.
- REQ-018: With REPEAT_TICKS=R>0, a key held pressed SHALL generate an additional event every R ticks after its press event, until released.
- REQ-019: When several keys produce events on the same tick, only the lowest index SHALL be applied; others SHALL be dropped.
- REQ-020: An event for key i SHALL add (dir=0) or subtract (dir=1) 10^i with full decimal carry/borrow across all DIGITS in one step; num SHALL always be valid BCD.
- REQ-021: Up from value 10^DIGITS-10^i or above SHALL wrap modulo 10^DIGITS and pulse ovf; down below zero SHALL wrap modulo 10^DIGITS (e.g. 0 - 1 -> all 9s) and pulse ovf.
- REQ-022: num, upd and ovf SHALL update on the rising edge one cycle after the tick cycle; upd and ovf high for exactly one cycle.
- REQ-023: clr high SHALL set num to 0 and pulse upd on the next edge, overriding any same-cycle key event (event dropped, no ovf); debounce and divider state unaffected.
- REQ-024: en SHALL go high on the edge ending the first tick cycle and stay high until reset.

Reset
- REQ-025: rst_n low SHALL asynchronously set num=0, en=0, upd=0, ovf=0, all debounced states released, repeat counters 0, divider to SAMPLE_DIV-1, synchronisers to 1 (released).
- REQ-026: Reset asserted mid-debounce or mid-repeat SHALL discard the pending event; after release no event is generated until a fresh 2-tick low sample.

Verification (SAMPLE_DIV=4, DIGITS=6, KEYS=4 unless stated)
- REQ-027: Hold key[0] low for 3 ticks, dir=0 -> exactly one upd pulse, num=0x000001; en high after first tick.
- REQ-028: Preload num=0x000099 via key presses, press key[0] -> num=0x000100, no ovf.
- REQ-029: num=0x999999, press key[0] dir=0 -> num=0x000000, ovf=1 for one cycle; then press key[0] dir=1 -> num=0x999999, ovf=1.
- REQ-030: key[1] and key[3] go low simultaneously from num=0 -> num=0x000010 only; key[3] event dropped.
- REQ-031: REPEAT_TICKS=3, hold key[2] for 11 ticks after press event -> num=0x000400 (initial + 3 repeats), then release -> no further change.
- REQ-032: clr pulsed in the same cycle a key event would apply -> num=0, upd=1, ovf=0; rst_n pulsed while key low for 1 tick -> no event after release until two fresh low samples.
